// File: rtl/rv_mem_pkg.sv
// Shared MEM-stage types: func3 size codes and LSU state encoding.
// Imported by the load/store unit and its lane aligner.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RDWAIT
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Store lane shifting / byte enables and load lane extraction / extension.
// Purely combinational; addr_lo selects the byte lane within the word.
import rv_mem_pkg::*;

module lsu_align (
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic        is_b;
  logic        is_h;
  logic [31:0] ld_sh;

  assign is_b  = (func3 == F3_B) || (func3 == F3_BU);
  assign is_h  = (func3 == F3_H) || (func3 == F3_HU);
  assign ld_sh = ld_word >> {addr_lo, 3'b000};

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    unique case (1'b1)
      is_b: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      is_h: begin
        be    = 4'b0011 << addr_lo;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    case (func3)
      F3_B:    ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_BU:   ld_data = {24'h0, ld_sh[7:0]};
      F3_H:    ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_HU:   ld_data = {16'h0, ld_sh[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: data-bus FSM, store forwarding, MEM/WB register.
// Stalls upstream while a bus access is outstanding.
import rv_mem_pkg::*;

module mem_stage_lsu #(
  parameter int BE_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     me_alu_out,
  input  logic [31:0]     me_rs2_data_st,
  input  logic [4:0]      me_rs2,
  input  logic [4:0]      me_rd,
  input  logic [2:0]      me_func3,
  input  logic            me_mem_read_ena,
  input  logic            me_mem_write_ena,
  input  logic            me_reg_write_ena,
  input  logic            me_mem2reg,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [31:0]     dbus_addr,
  output logic [BE_W-1:0] dbus_be,
  output logic [31:0]     dbus_wdata,
  input  logic            dbus_gnt,
  input  logic            dbus_rvalid,
  input  logic [31:0]     dbus_rdata,
  output logic            mem_stall,
  output logic            mem_misaligned,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write_ena,
  output logic [31:0]     wb_data
);

  lsu_state_e  state, state_nxt;
  logic        access;
  logic        misaligned;
  logic        issue;
  logic        done;
  logic        latch_en;
  logic        fwd;
  logic [31:0] st_src;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [31:0] ld_data;

  logic [29:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        lat_we;

  assign access = me_mem_read_ena | me_mem_write_ena;

  assign misaligned = access &
    ((((me_func3 == F3_H) || (me_func3 == F3_HU)) && me_alu_out[0]) ||
     ((me_func3 == F3_W) && (me_alu_out[1:0] != 2'b00)));

  assign issue = access & ~misaligned;

  // WB goes to a bubble during a stall, so forwarding is only valid in IDLE
  assign fwd = wb_reg_write_ena && (wb_rd != 5'd0) && (wb_rd == me_rs2);
  assign st_src = fwd ? wb_data : me_rs2_data_st;

  lsu_align u_align (
    .addr_lo (me_alu_out[1:0]),
    .func3   (me_func3),
    .st_data (st_src),
    .ld_word (dbus_rdata),
    .be      (al_be),
    .wdata   (al_wdata),
    .ld_data (ld_data)
  );

  always_comb begin
    state_nxt  = state;
    dbus_req   = 1'b0;
    dbus_we    = me_mem_write_ena;
    dbus_addr  = {me_alu_out[31:2], 2'b00};
    dbus_be    = al_be;
    dbus_wdata = al_wdata;
    done       = 1'b0;
    latch_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        dbus_req = issue;
        if (issue) begin
          if (dbus_gnt) begin
            if (me_mem_write_ena) done = 1'b1;
            else state_nxt = S_RDWAIT;
          end else begin
            state_nxt = S_REQ;
            latch_en  = 1'b1;
          end
        end
      end
      S_REQ: begin
        dbus_req   = 1'b1;
        dbus_we    = lat_we;
        dbus_addr  = {lat_addr, 2'b00};
        dbus_be    = lat_be;
        dbus_wdata = lat_wdata;
        if (dbus_gnt) begin
          if (lat_we) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        if (dbus_rvalid) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reset) dbus_req = 1'b0;
  end

  assign mem_stall = issue & ~done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_we    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch_en) begin
        lat_addr  <= me_alu_out[31:2];
        lat_wdata <= al_wdata;
        lat_be    <= al_be;
        lat_we    <= me_mem_write_ena;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_rd            <= '0;
      wb_reg_write_ena <= 1'b0;
      wb_data          <= '0;
      mem_misaligned   <= 1'b0;
    end else begin
      mem_misaligned <= 1'b0;
      if (mem_stall) begin
        wb_reg_write_ena <= 1'b0;
      end else if (misaligned) begin
        wb_reg_write_ena <= 1'b0;
        mem_misaligned   <= 1'b1;
      end else begin
        wb_rd            <= me_rd;
        wb_reg_write_ena <= me_reg_write_ena;
        wb_data          <= me_mem2reg ? ld_data : me_alu_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, forwarding, misalign, reset.
// Inputs change 1 time unit after posedge; outputs are sampled before the next edge.
module tb_mem_stage_lsu;
  import rv_mem_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] me_alu_out;
  logic [31:0] me_rs2_data_st;
  logic [4:0]  me_rs2;
  logic [4:0]  me_rd;
  logic [2:0]  me_func3;
  logic        me_mem_read_ena;
  logic        me_mem_write_ena;
  logic        me_reg_write_ena;
  logic        me_mem2reg;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic        mem_misaligned;
  logic [4:0]  wb_rd;
  logic        wb_reg_write_ena;
  logic [31:0] wb_data;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  mem_stage_lsu #(.BE_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .me_alu_out       (me_alu_out),
    .me_rs2_data_st   (me_rs2_data_st),
    .me_rs2           (me_rs2),
    .me_rd            (me_rd),
    .me_func3         (me_func3),
    .me_mem_read_ena  (me_mem_read_ena),
    .me_mem_write_ena (me_mem_write_ena),
    .me_reg_write_ena (me_reg_write_ena),
    .me_mem2reg       (me_mem2reg),
    .dbus_req         (dbus_req),
    .dbus_we          (dbus_we),
    .dbus_addr        (dbus_addr),
    .dbus_be          (dbus_be),
    .dbus_wdata       (dbus_wdata),
    .dbus_gnt         (dbus_gnt),
    .dbus_rvalid      (dbus_rvalid),
    .dbus_rdata       (dbus_rdata),
    .mem_stall        (mem_stall),
    .mem_misaligned   (mem_misaligned),
    .wb_rd            (wb_rd),
    .wb_reg_write_ena (wb_reg_write_ena),
    .wb_data          (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble;
    me_alu_out       = 32'h0;
    me_rs2_data_st   = 32'h0;
    me_rs2           = 5'd0;
    me_rd            = 5'd0;
    me_func3         = F3_W;
    me_mem_read_ena  = 1'b0;
    me_mem_write_ena = 1'b0;
    me_reg_write_ena = 1'b0;
    me_mem2reg       = 1'b0;
    dbus_gnt         = 1'b0;
    dbus_rvalid      = 1'b0;
    dbus_rdata       = 32'h0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [2:0] f3,
                          input logic [4:0] rd);
    bubble();
    me_alu_out       = a;
    me_func3         = f3;
    me_rd            = rd;
    me_mem_read_ena  = 1'b1;
    me_reg_write_ena = 1'b1;
    me_mem2reg       = 1'b1;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [2:0] f3,
                           input logic [4:0] rs2, input logic [31:0] d);
    bubble();
    me_alu_out       = a;
    me_func3         = f3;
    me_rs2           = rs2;
    me_rs2_data_st   = d;
    me_mem_write_ena = 1'b1;
  endtask

  // grant in the issue cycle, rvalid in the next; WB is updated on return
  task automatic quick_load(input string tag, input logic [31:0] a,
                            input logic [2:0] f3, input logic [31:0] rd_word);
    set_load(a, f3, 5'd3);
    dbus_gnt = 1'b1;
    #1;
    chk({tag, "_stall0"}, mem_stall, 1);
    step();
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata  = rd_word;
    #1;
    chk({tag, "_stall1"}, mem_stall, 0);
    step();
    bubble();
  endtask

  initial begin
    bubble();
    reset = 1'b1;
    step();
    step();
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_we", wb_reg_write_ena, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mis", mem_misaligned, 0);
    chk("rst_req", dbus_req, 0);
    reset = 1'b0;

    set_load(32'h100, F3_W, 5'd7);
    dbus_gnt = 1'b1;
    #1;
    chk("lw_req", dbus_req, 1);
    chk("lw_we", dbus_we, 0);
    chk("lw_addr", dbus_addr, 32'h100);
    chk("lw_stall0", mem_stall, 1);
    step();
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata  = 32'hDEADBEEF;
    #1;
    chk("lw_rdwait_req", dbus_req, 0);
    chk("lw_stall1", mem_stall, 0);
    chk("lw_bubble_we", wb_reg_write_ena, 0);
    step();
    bubble();
    chk("lw_wb_data", wb_data, 32'hDEADBEEF);
    chk("lw_wb_we", wb_reg_write_ena, 1);
    chk("lw_wb_rd", wb_rd, 7);

    quick_load("lb", 32'h103, F3_B, 32'h80112233);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    quick_load("lbu", 32'h103, F3_BU, 32'h80112233);
    chk("lbu_data", wb_data, 32'h00000080);
    quick_load("lh", 32'h102, F3_H, 32'h80112233);
    chk("lh_data", wb_data, 32'hFFFF8011);
    quick_load("lhu", 32'h102, F3_HU, 32'h80112233);
    chk("lhu_data", wb_data, 32'h00008011);
    quick_load("lb0", 32'h100, F3_B, 32'h80112233);
    chk("lb0_data", wb_data, 32'h00000033);

    // sb with grant on the fourth cycle: three stall cycles
    step();
    set_store(32'h201, F3_B, 5'd4, 32'h000000AB);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("sb_req%0d", i), dbus_req, 1);
      chk($sformatf("sb_be%0d", i), dbus_be, 4'b0010);
      chk($sformatf("sb_wd%0d", i), dbus_wdata, 32'hABABABAB);
      chk($sformatf("sb_addr%0d", i), dbus_addr, 32'h200);
      chk($sformatf("sb_stall%0d", i), mem_stall, 1);
      step();
    end
    dbus_gnt = 1'b1;
    #1;
    chk("sb_gnt_we", dbus_we, 1);
    chk("sb_gnt_wd", dbus_wdata, 32'hABABABAB);
    chk("sb_gnt_stall", mem_stall, 0);
    step();
    bubble();
    chk("sb_wb_we", wb_reg_write_ena, 0);

    // sh at lane 2 granted immediately: no stall
    set_store(32'h202, F3_H, 5'd4, 32'h00005678);
    dbus_gnt = 1'b1;
    #1;
    chk("sh_be", dbus_be, 4'b1100);
    chk("sh_wd", dbus_wdata, 32'h56785678);
    chk("sh_stall", mem_stall, 0);
    step();

    // add x5 <- 0x1234 then sw x5 with stale data, grant after 2 cycles
    bubble();
    me_alu_out       = 32'h1234;
    me_rd            = 5'd5;
    me_reg_write_ena = 1'b1;
    #1;
    chk("add_stall", mem_stall, 0);
    step();
    chk("add_wb_data", wb_data, 32'h1234);
    set_store(32'h300, F3_W, 5'd5, 32'hBAD0BAD0);
    #1;
    chk("fwd_wd0", dbus_wdata, 32'h00001234);
    chk("fwd_be0", dbus_be, 4'b1111);
    step();
    #1;
    chk("fwd_wb_bubble", wb_reg_write_ena, 0);
    chk("fwd_wd1", dbus_wdata, 32'h00001234);
    step();
    dbus_gnt = 1'b1;
    #1;
    chk("fwd_wd2", dbus_wdata, 32'h00001234);
    chk("fwd_addr2", dbus_addr, 32'h300);
    chk("fwd_stall2", mem_stall, 0);
    step();

    set_load(32'h102, F3_W, 5'd8);
    dbus_gnt = 1'b1;
    #1;
    chk("mis_req", dbus_req, 0);
    chk("mis_stall", mem_stall, 0);
    step();
    bubble();
    #1;
    chk("mis_pulse", mem_misaligned, 1);
    chk("mis_wb_we", wb_reg_write_ena, 0);
    step();
    chk("mis_pulse_end", mem_misaligned, 0);

    // reset while waiting for rvalid
    me_alu_out       = 32'h77;
    me_rd            = 5'd9;
    me_reg_write_ena = 1'b1;
    step();
    set_load(32'h100, F3_W, 5'd10);
    dbus_gnt = 1'b1;
    step();
    chk("rw_wb_rd_hold", wb_rd, 9);
    chk("rw_wb_data_hold", wb_data, 32'h77);
    bubble();
    reset = 1'b1;
    #1;
    chk("rw_req_in_rst", dbus_req, 0);
    step();
    chk("rw_wb_rd", wb_rd, 0);
    chk("rw_wb_data", wb_data, 0);
    chk("rw_wb_we", wb_reg_write_ena, 0);
    chk("rw_mis", mem_misaligned, 0);
    reset = 1'b0;
    set_load(32'h100, F3_W, 5'd11);
    dbus_rvalid = 1'b1;
    dbus_rdata  = 32'h55;
    #1;
    chk("rw_idle_req", dbus_req, 1);
    chk("rw_stray_stall", mem_stall, 1);
    step();
    chk("rw_stray_we", wb_reg_write_ena, 0);
    dbus_rvalid = 1'b0;
    dbus_gnt    = 1'b1;
    #1;
    chk("rw_req_state", dbus_req, 1);
    step();
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata  = 32'h99887766;
    step();
    bubble();
    chk("rw_final_data", wb_data, 32'h99887766);
    chk("rw_final_rd", wb_rd, 11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
